// File: rtl/screen_pkg.sv
// Shared constants and scan-state type for the 512x256 mono screen scanner.
// Feature macro: SCREEN_SCAN_FRAME_CNT_EN (adds frame_cnt output).
package screen_pkg;

  localparam int SCREEN_WORDS  = 8192;
  localparam int WORDS_PER_ROW = 32;
  localparam int ROWS          = 256;
  localparam int PIX_PER_WORD  = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/screen_word_shifter.sv
// Holds the 16-bit word being emitted, LSB first, with pixel index.
// Feature macro: SCREEN_SCAN_FRAME_CNT_EN (not used here).
module screen_word_shifter
  import screen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [15:0] i_word,
  input  logic        i_shift,
  output logic        o_valid,
  output logic        o_bit,
  output logic [3:0]  o_idx,
  output logic        o_last
);

  logic [15:0] r_sr;
  logic [3:0]  r_idx;
  logic        r_valid;

  // Load a new word, or step to the next pixel on each accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_sr    <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_sr    <= i_word;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (i_shift && r_valid) begin
      if (o_last) begin
        r_sr    <= '0;
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_sr  <= r_sr >> 1;
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_bit   = r_valid & r_sr[0];
  assign o_idx   = r_idx;
  assign o_last  = (r_idx == 4'(PIX_PER_WORD - 1));

endmodule

// File: rtl/screen_scanner.sv
// Scans screen memory into a 1-bit pixel stream, one pixel per cycle.
// Feature macro: SCREEN_SCAN_FRAME_CNT_EN (adds frame_cnt output).
module screen_scanner
  import screen_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_sof,
  output logic              pix_eol
`ifdef SCREEN_SCAN_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int COL_W = $clog2(WORDS_PER_ROW);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(SCREEN_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD =
    ADDR_W'(ROWS * WORDS_PER_ROW - 1);
  localparam logic [COL_W-1:0] LAST_COL =
    COL_W'(WORDS_PER_ROW - 1);

  scan_state_t r_state;
  scan_state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_word;
  logic              r_pend;
  logic [15:0]       r_buf;
  logic              r_buf_v;

  logic        w_sh_valid;
  logic        w_sh_bit;
  logic [3:0]  w_sh_idx;
  logic        w_sh_last;
  logic        w_xfer;
  logic        w_sh_free;
  logic        w_ret;
  logic        w_frame_end;
  logic        w_stop;
  logic        w_sh_load;
  logic [15:0] w_sh_word;

  assign w_xfer      = w_sh_valid & pix_ready;
  assign w_sh_free   = ~w_sh_valid | (w_xfer & w_sh_last);
  assign w_ret       = r_pend;
  assign w_frame_end = w_xfer & w_sh_last & (r_word == LAST_WORD);
  assign w_stop      = (r_state == S_RUN) & w_frame_end & ~enable;
  assign w_sh_load   = ~w_stop & w_sh_free & (r_buf_v | w_ret);
  assign w_sh_word   = r_buf_v ? r_buf : mem_data;

  screen_word_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_stop),
    .i_load  (w_sh_load),
    .i_word  (w_sh_word),
    .i_shift (w_xfer),
    .o_valid (w_sh_valid),
    .o_bit   (w_sh_bit),
    .o_idx   (w_sh_idx),
    .o_last  (w_sh_last)
  );

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and read strobe: fetch when the prefetch slot frees up.
  always_comb begin
    w_next = r_state;
    mem_rd = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_RUN;
      end
      S_RUN: begin
        mem_rd = ~r_pend & (~r_buf_v | w_sh_free) & ~w_stop;
        if (w_stop) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read address, outstanding flag, word position and prefetch buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_word  <= '0;
      r_pend  <= 1'b0;
      r_buf   <= '0;
      r_buf_v <= 1'b0;
    end else if (w_stop) begin
      r_addr  <= '0;
      r_word  <= '0;
      r_pend  <= 1'b0;
      r_buf_v <= 1'b0;
    end else begin
      r_pend <= mem_rd;
      if (mem_rd)
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
      if (w_xfer && w_sh_last)
        r_word <= (r_word == LAST_WORD) ? '0 : r_word + 1'b1;
      if (w_sh_free && r_buf_v) begin
        r_buf_v <= w_ret;
        if (w_ret) r_buf <= mem_data;
      end else if (w_ret && !w_sh_free) begin
        r_buf_v <= 1'b1;
        r_buf   <= mem_data;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign pix_valid = w_sh_valid;
  assign pix_data  = w_sh_bit;
  assign pix_sof   = w_sh_valid & (r_word == '0) & (w_sh_idx == 4'd0);
  assign pix_eol   = w_sh_valid & w_sh_last &
                     (r_word[COL_W-1:0] == LAST_COL);

`ifdef SCREEN_SCAN_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count completed frames (final pixel accepted).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_frame_cnt <= '0;
    else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_screen_scanner.sv
// Self-checking bench for screen_scanner against a pixel-index model.
// Feature macro: SCREEN_SCAN_FRAME_CNT_EN (frame_cnt checked when set).
module tb_screen_scanner;

  localparam int AW   = 13;
  localparam int NPIX = 131072;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_data;
  logic          pix_sof;
  logic          pix_eol;
`ifdef SCREEN_SCAN_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [15:0] mem [0:8191];

  screen_scanner #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol)
`ifdef SCREEN_SCAN_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after the strobe; garbage otherwise.
  always @(posedge clk)
    mem_data <= mem_rd ? mem[mem_addr] : 16'($urandom);

  // Pixel n of the endless stream: {data, sof, eol}.
  function automatic logic [2:0] exp_px(input int n);
    logic [15:0] w;
    w = mem[(n / 16) % 8192];
    return {w[n % 16], (n % NPIX) == 0, (n % 512) == 511};
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 8192; k++) mem[k] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_rd, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_rd got rd=%b addr=%0d want 0/0",
               mem_rd, mem_addr);
    end
    vectors++;
    if ({pix_valid, pix_data, pix_sof, pix_eol} !== 4'b0) begin
      errors++;
      $display("FAIL reset_pix got %b want 0000",
               {pix_valid, pix_data, pix_sof, pix_eol});
    end
`ifdef SCREEN_SCAN_FRAME_CNT_EN
    vectors++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_fcnt got %0d want 0", frame_cnt);
    end
`endif
  endtask

  task automatic test_sequential();
    int n = 0;
    int nrd = 1;
    logic [2:0] e;
    for (int k = 0; k < 8192; k++) mem[k] = 16'(k);
    do_reset();
    enable    = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (!(mem_rd === 1'b1 && mem_addr === '0)) begin
      errors++;
      $display("FAIL first_rd got rd=%b addr=%0d want 1/0",
               mem_rd, mem_addr);
    end
    @(negedge clk);
    vectors++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid got %b want 0", pix_valid);
    end
    @(negedge clk);
    vectors++;
    if (pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_valid got %b want 1", pix_valid);
    end
    for (int c = 0; c < 4000; c++) begin
      vectors++;
      if (pix_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_gap cyc=%0d got %b want 1", c, pix_valid);
      end
      if (pix_valid && pix_ready) begin
        e = exp_px(n);
        vectors++;
        if ({pix_data, pix_sof, pix_eol} !== e) begin
          errors++;
          $display("FAIL seq_pix px=%0d got %b want %b", n,
                   {pix_data, pix_sof, pix_eol}, e);
        end
        n++;
      end
      if (mem_rd) begin
        vectors++;
        if (mem_addr !== AW'(nrd)) begin
          errors++;
          $display("FAIL seq_addr got %0d want %0d", mem_addr, nrd);
        end
        nrd = (nrd + 1) % 8192;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_first_word();
    int n = 0;
    int c = 0;
    logic [2:0] e;
    fill_random();
    mem[0] = 16'h0001;
    do_reset();
    enable    = 1'b1;
    pix_ready = 1'b1;
    while (n < 512 && c < 600) begin
      @(negedge clk);
      c++;
      if (pix_valid && pix_ready) begin
        e = exp_px(n);
        vectors++;
        if ({pix_data, pix_sof, pix_eol} !== e) begin
          errors++;
          $display("FAIL word0_pix px=%0d got %b want %b", n,
                   {pix_data, pix_sof, pix_eol}, e);
        end
        if (n == 0) begin
          vectors++;
          if ({pix_data, pix_sof} !== 2'b11) begin
            errors++;
            $display("FAIL word0_sof got %b want 11",
                     {pix_data, pix_sof});
          end
        end
        if (n == 511) begin
          vectors++;
          if (pix_eol !== 1'b1) begin
            errors++;
            $display("FAIL word0_eol got %b want 1", pix_eol);
          end
        end
        n++;
      end
    end
    vectors++;
    if (n != 512) begin
      errors++;
      $display("FAIL word0_count got %0d want 512", n);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    int reads = 0;
    bit seen = 0;
    logic [2:0] snap;
    logic [2:0] e;
    fill_random();
    do_reset();
    enable    = 1'b1;
    pix_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_rd) reads++;
      if (pix_valid) begin
        if (!seen) begin
          snap = {pix_data, pix_sof, pix_eol};
          seen = 1;
        end
        vectors++;
        if ({pix_data, pix_sof, pix_eol} !== snap) begin
          errors++;
          $display("FAIL stall_stable cyc=%0d got %b want %b", c,
                   {pix_data, pix_sof, pix_eol}, snap);
        end
      end
    end
    vectors++;
    if (reads != 2) begin
      errors++;
      $display("FAIL stall_reads got %0d want 2", reads);
    end
    vectors++;
    if (pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid got %b want 1", pix_valid);
    end
    pix_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (pix_valid && pix_ready) begin
        e = exp_px(n);
        vectors++;
        if ({pix_data, pix_sof, pix_eol} !== e) begin
          errors++;
          $display("FAIL stall_pix px=%0d got %b want %b", n,
                   {pix_data, pix_sof, pix_eol}, e);
        end
        n++;
      end
      @(negedge clk);
    end
    vectors++;
    if (n != 200) begin
      errors++;
      $display("FAIL stall_resume got %0d want 200", n);
    end
  endtask

  task automatic test_two_frames();
    int n = 0;
    int nrd = 0;
    int wraps = 0;
    int c = 0;
    logic [2:0] e;
    fill_random();
    do_reset();
    enable = 1'b1;
    while (n < 2 * NPIX && c < 800000) begin
      @(negedge clk);
      c++;
      pix_ready = 1'($urandom_range(0, 1));
      if (mem_rd) begin
        vectors++;
        if (mem_addr !== AW'(nrd)) begin
          errors++;
          $display("FAIL frm_addr got %0d want %0d", mem_addr, nrd);
        end
        if (nrd == 0 && c > 5) wraps++;
        nrd = (nrd + 1) % 8192;
      end
      if (pix_valid && pix_ready) begin
        e = exp_px(n);
        vectors++;
        if ({pix_data, pix_sof, pix_eol} !== e) begin
          errors++;
          $display("FAIL frm_pix px=%0d got %b want %b", n,
                   {pix_data, pix_sof, pix_eol}, e);
        end
        if (n == NPIX + 1000) enable = 1'b0;
        n++;
      end
    end
    vectors++;
    if (n != 2 * NPIX) begin
      errors++;
      $display("FAIL frm_timeout got %0d want %0d", n, 2 * NPIX);
    end
    vectors++;
    if (mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL frm_end_rd got %b want 0", mem_rd);
    end
    vectors++;
    if (wraps < 1) begin
      errors++;
      $display("FAIL frm_wrap got %0d want >=1", wraps);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if ({mem_rd, pix_valid} !== 2'b00) begin
        errors++;
        $display("FAIL frm_idle got %b want 00", {mem_rd, pix_valid});
      end
    end
`ifdef SCREEN_SCAN_FRAME_CNT_EN
    vectors++;
    if (frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL frm_cnt got %0d want 2", frame_cnt);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int c = 0;
    logic [2:0] e;
    fill_random();
    do_reset();
    enable    = 1'b1;
    pix_ready = 1'b1;
    while (n < 300 && c < 400) begin
      @(negedge clk);
      c++;
      if (pix_valid) n++;
    end
    c = 0;
    while (!mem_rd && c < 40) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL mrst_rd got %b want 1", mem_rd);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eol}
        !== '0) begin
      errors++;
      $display("FAIL mrst_out got rd=%b addr=%0d pix=%b want 0",
               mem_rd, mem_addr,
               {pix_valid, pix_data, pix_sof, pix_eol});
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (!(mem_rd === 1'b1 && mem_addr === '0)) begin
      errors++;
      $display("FAIL mrst_restart got rd=%b addr=%0d want 1/0",
               mem_rd, mem_addr);
    end
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (pix_valid && pix_ready) begin
        e = exp_px(n);
        vectors++;
        if ({pix_data, pix_sof, pix_eol} !== e) begin
          errors++;
          $display("FAIL mrst_pix px=%0d got %b want %b", n,
                   {pix_data, pix_sof, pix_eol}, e);
        end
        n++;
      end
      @(negedge clk);
    end
    vectors++;
    if (n != 298) begin
      errors++;
      $display("FAIL mrst_count got %0d want 298", n);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    pix_ready = 1'b0;
    test_reset();
    test_sequential();
    test_first_word();
    test_stall();
    test_two_frames();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/screen_scanner.md
SCREEN_SCANNER -- requirements
Module: screen_scanner

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, the screen-memory word address width (8192 words).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  request continuous frame scanning.
REQ-006 mem_rd  output  1  read strobe to screen memory, one cycle per word.
REQ-007 mem_addr  output  ADDR_W  word address, row*32+col.
REQ-008 mem_data  input  16  read data, valid exactly 1 cycle after mem_rd.
REQ-009 pix_valid  output  1  pixel available.
REQ-010 pix_ready  input  1  consumer accepts pixel.
REQ-011 pix_data  output  1  pixel value, 1 = black.
REQ-012 pix_sof  output  1  current pixel is x=0, y=0.
REQ-013 pix_eol  output  1  current pixel is x=511.

Function
REQ-014 The block SHALL implement states IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE after the pixel x=511,y=255 transfers with enable=0.
REQ-015 A transfer SHALL occur when pix_valid=1 and pix_ready=1; pix_data, pix_sof and pix_eol SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-016 Pixels SHALL emit word-LSB first: bit 0 of word (y*32+c) is pixel x=16*c.
REQ-017 The block SHALL use a current-word shifter plus one prefetch buffer word, with at most one read outstanding and at most 2 words fetched ahead of the pixel in transfer.
REQ-018 mem_rd SHALL issue whenever in RUN, the buffer is empty (or emptying this cycle) and no read is outstanding.
REQ-019 The first mem_rd (addr 0) SHALL be the cycle after enable is sampled 1 in IDLE, and the first pix_valid SHALL come 2 cycles after that mem_rd.
REQ-020 Throughput SHALL be 1 pixel/cycle sustained while pix_ready=1, with no bubble between words or at the 8191->0 wrap.
REQ-021 The address SHALL wrap from 8191 to 0 for the next frame when enable=1.
REQ-022 With pix_ready=0 held, reads SHALL stop once the shifter and buffer are full, and no data SHALL be lost.
REQ-023 enable=0 mid-frame SHALL take effect only at the frame end, where prefetched words are discarded and mem_rd=0.
REQ-024 enable re-asserted in the same cycle as the final transfer SHALL continue into the next frame without entering IDLE.

Reset
REQ-025 Reset SHALL force state IDLE, mem_rd=0, mem_addr=0, pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, buffer empty and no read outstanding.
REQ-026 Reset SHALL take effect immediately mid-frame, a read returning after reset release SHALL be ignored, and the next enable SHALL restart at addr 0.

Configuration
REQ-027 When macro SCREEN_SCAN_FRAME_CNT_EN is defined, output frame_cnt[15:0] SHALL exist, reset to 0 and increment (wrapping) on each transfer with x=511,y=255.
REQ-028 When SCREEN_SCAN_FRAME_CNT_EN is undefined, the frame_cnt port and its counter SHALL be absent.

Structure
REQ-029 Package screen_pkg SHALL hold SCREEN_WORDS=8192, WORDS_PER_ROW=32, ROWS=256, PIX_PER_WORD=16 and the scan state enum typedef.
REQ-030 Sub-module screen_word_shifter SHALL implement the loadable 16-bit shift register with its 4-bit pixel index and a last-pixel flag.

Verification
REQ-031 The bench SHALL check: reset, enable=1, pix_ready=1, memory word k=k -> mem_rd at addr 0 one cycle after enable, pix_valid 2 cycles later, pixels match bits of 0,1,2..., and no gaps.
REQ-032 The bench SHALL check: word 0=16'h0001 -> first pixel 1 with pix_sof=1, next 15 pixels 0; pix_eol=1 on the 512th pixel.
REQ-033 The bench SHALL check: pix_ready=0 for 100 cycles -> exactly 2 reads issued, outputs stable, and the stream resumes intact.
REQ-034 The bench SHALL check: pix_ready toggling at random 50% over 2 full frames -> 262144 pixels match memory, addr wraps 8191->0, and frame_cnt=2 when enabled.
REQ-035 The bench SHALL check: enable dropped at pixel 1000 -> scanning completes to x=511,y=255, then IDLE with mem_rd=0 and pix_valid=0.
REQ-036 The bench SHALL check: rst_n pulsed mid-frame with a read outstanding -> all outputs reset immediately, and the next frame starts at addr 0 with pix_sof.
